// File: rtl/vram_rect_fill_if.sv
// rtl/vram_rect_fill_if.sv - register, CPU store and VRAM port A bundle for vram_rect_fill
// The master side is the register/CPU client and the VRAM sink; the slave side is the fill engine.
interface vram_rect_fill_if;
   logic        reg_we;
   logic [2:0]  reg_addr;
   logic [31:0] reg_wdata;
   logic [31:0] reg_rdata;
   logic        cpu_vram_we;
   logic [13:0] cpu_vram_addr;
   logic [31:0] cpu_vram_wdata;
   logic        vram_we;
   logic [13:0] vram_addr;
   logic [31:0] vram_wdata;
   logic        busy;
   logic        done_pulse;

   modport master (
      output reg_we, reg_addr, reg_wdata, cpu_vram_we, cpu_vram_addr, cpu_vram_wdata,
      input  reg_rdata, vram_we, vram_addr, vram_wdata, busy, done_pulse
   );

   modport slave (
      input  reg_we, reg_addr, reg_wdata, cpu_vram_we, cpu_vram_addr, cpu_vram_wdata,
      output reg_rdata, vram_we, vram_addr, vram_wdata, busy, done_pulse
   );
endinterface

// File: rtl/vram_rect_fill.sv
// rtl/vram_rect_fill.sv - rectangle-fill engine writing tile colours into VRAM port A
// CPU stores share the port and always win; the engine stalls in place while one is forwarded.
module vram_rect_fill #(
   parameter int COLS       = 80,
   parameter int ROWS       = 60,
   parameter int PAGE0_BASE = 2048,
   parameter int PAGE1_BASE = 6848
) (
   input logic             clk,
   input logic             rst,
   vram_rect_fill_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_RUN, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [6:0]  x0_q, x0_d;
   logic [5:0]  y0_q, y0_d;
   logic [6:0]  w_q, w_d;
   logic [5:0]  h_q, h_d;
   logic [31:0] color_q, color_d;
   logic        page_q, page_d;
   logic [31:0] color_w_q, color_w_d;
   logic        page_w_q, page_w_d;
   logic        sticky_q, sticky_d;
   logic [6:0]  col_q, col_d;
   logic [5:0]  row_q, row_d;
   logic [6:0]  weff_q, weff_d;
   logic [5:0]  heff_q, heff_d;
   logic [13:0] row_addr_q, row_addr_d;

   logic [6:0]  w_room, w_clip;
   logic [5:0]  h_room, h_clip;
   logic [13:0] y0_x80, page_base;
   logic        cfg_wr;

   // Clip the rectangle against the right and bottom screen edges.
   assign w_room    = 7'(COLS) - x0_q;
   assign h_room    = 6'(ROWS) - y0_q;
   assign w_clip    = (x0_q >= 7'(COLS)) ? 7'd0 : ((w_q < w_room) ? w_q : w_room);
   assign h_clip    = (y0_q >= 6'(ROWS)) ? 6'd0 : ((h_q < h_room) ? h_q : h_room);
   assign y0_x80    = ({8'd0, y0_q} << 6) + ({8'd0, y0_q} << 4);
   assign page_base = page_w_q ? 14'(PAGE1_BASE) : 14'(PAGE0_BASE);
   assign cfg_wr    = bus.reg_we && (state_q == S_IDLE);
   assign bus.busy  = (state_q != S_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         x0_q       <= '0;
         y0_q       <= '0;
         w_q        <= '0;
         h_q        <= '0;
         color_q    <= '0;
         page_q     <= 1'b0;
         color_w_q  <= '0;
         page_w_q   <= 1'b0;
         sticky_q   <= 1'b0;
         col_q      <= '0;
         row_q      <= '0;
         weff_q     <= '0;
         heff_q     <= '0;
         row_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         x0_q       <= x0_d;
         y0_q       <= y0_d;
         w_q        <= w_d;
         h_q        <= h_d;
         color_q    <= color_d;
         page_q     <= page_d;
         color_w_q  <= color_w_d;
         page_w_q   <= page_w_d;
         sticky_q   <= sticky_d;
         col_q      <= col_d;
         row_q      <= row_d;
         weff_q     <= weff_d;
         heff_q     <= heff_d;
         row_addr_q <= row_addr_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      x0_d           = x0_q;
      y0_d           = y0_q;
      w_d            = w_q;
      h_d            = h_q;
      color_d        = color_q;
      page_d         = page_q;
      color_w_d      = color_w_q;
      page_w_d       = page_w_q;
      sticky_d       = sticky_q;
      col_d          = col_q;
      row_d          = row_q;
      weff_d         = weff_q;
      heff_d         = heff_q;
      row_addr_d     = row_addr_q;
      bus.vram_we    = bus.cpu_vram_we;
      bus.vram_addr  = bus.cpu_vram_addr;
      bus.vram_wdata = bus.cpu_vram_wdata;
      bus.done_pulse = 1'b0;

      if (cfg_wr) begin
         case (bus.reg_addr)
            3'd0: x0_d    = bus.reg_wdata[6:0];
            3'd1: y0_d    = bus.reg_wdata[5:0];
            3'd2: w_d     = bus.reg_wdata[6:0];
            3'd3: h_d     = bus.reg_wdata[5:0];
            3'd4: color_d = bus.reg_wdata;
            3'd5: begin
               page_d = bus.reg_wdata[1];
               if (bus.reg_wdata[0]) begin
                  state_d   = S_SETUP;
                  page_w_d  = bus.reg_wdata[1];
                  color_w_d = color_q;
               end
            end
            default: ;
         endcase
      end
      if (bus.reg_we && (bus.reg_addr == 3'd6) && bus.reg_wdata[1]) begin
         sticky_d = 1'b0;
      end

      case (state_q)
         S_SETUP: begin
            weff_d     = w_clip;
            heff_d     = h_clip;
            row_addr_d = page_base + y0_x80;
            col_d      = '0;
            row_d      = '0;
            state_d    = ((w_clip == 7'd0) || (h_clip == 6'd0)) ? S_DONE : S_RUN;
         end
         S_RUN: begin
            if (!bus.cpu_vram_we) begin
               bus.vram_we    = 1'b1;
               bus.vram_addr  = row_addr_q + {7'd0, x0_q} + {7'd0, col_q};
               bus.vram_wdata = color_w_q;
               if (col_q == weff_q - 7'd1) begin
                  col_d = '0;
                  if (row_q == heff_q - 6'd1) begin
                     state_d = S_DONE;
                  end else begin
                     row_d      = row_q + 6'd1;
                     row_addr_d = row_addr_q + 14'(COLS);
                  end
               end else begin
                  col_d = col_q + 7'd1;
               end
            end
         end
         S_DONE: begin
            bus.done_pulse = 1'b1;
            sticky_d       = 1'b1;
            state_d        = S_IDLE;
         end
         default: ;
      endcase
   end

   always_comb begin
      bus.reg_rdata = '0;
      case (bus.reg_addr)
         3'd0: bus.reg_rdata = {25'd0, x0_q};
         3'd1: bus.reg_rdata = {26'd0, y0_q};
         3'd2: bus.reg_rdata = {25'd0, w_q};
         3'd3: bus.reg_rdata = {26'd0, h_q};
         3'd4: bus.reg_rdata = color_q;
         3'd5: bus.reg_rdata = {30'd0, page_q, 1'b0};
         3'd6: bus.reg_rdata = {30'd0, sticky_q, bus.busy};
         default: bus.reg_rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_vram_rect_fill.sv
// tb/tb_vram_rect_fill.sv - directed self-checking bench for vram_rect_fill
// Cycle 1 is the cycle right after the start edge; latency is the cycle index holding done_pulse.
module tb_vram_rect_fill;
   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   logic [13:0] wa[$];
   logic [31:0] wd[$];
   int          wc[$];
   int          fwd_seen;
   bit          fwd_ok;

   vram_rect_fill_if bus ();

   vram_rect_fill dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic reg_wr(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.reg_we    = 1'b1;
      bus.reg_addr  = a;
      bus.reg_wdata = d;
      @(posedge clk);
      #1;
      bus.reg_we = 1'b0;
   endtask

   task automatic reg_rd(input logic [2:0] a, output logic [31:0] d);
      bus.reg_addr = a;
      #1;
      d = bus.reg_rdata;
   endtask

   task automatic setup_rect(input int x, input int y, input int w, input int h, input logic [31:0] c);
      reg_wr(3'd0, 32'(x));
      reg_wr(3'd1, 32'(y));
      reg_wr(3'd2, 32'(w));
      reg_wr(3'd3, 32'(h));
      reg_wr(3'd4, c);
   endtask

   task automatic start(input bit page);
      reg_wr(3'd5, {30'd0, page, 1'b1});
   endtask

   // Observes engine writes until done_pulse or the cycle budget runs out (lat stays -1).
   task automatic capture(input int max_c, input int stall_c, input bit poke, output int lat);
      int c;
      wa.delete(); wd.delete(); wc.delete();
      fwd_seen = 0;
      fwd_ok   = 1'b0;
      lat      = -1;
      c        = 0;
      while (c < max_c && lat < 0) begin
         c++;
         bus.cpu_vram_we    = (c == stall_c);
         bus.cpu_vram_addr  = 14'h0100;
         bus.cpu_vram_wdata = 32'hDEAD_BEEF;
         bus.reg_we         = 1'b0;
         if (poke && c == 2) begin bus.reg_we = 1'b1; bus.reg_addr = 3'd0; bus.reg_wdata = 32'd0; end
         if (poke && c == 3) begin bus.reg_we = 1'b1; bus.reg_addr = 3'd5; bus.reg_wdata = 32'd3; end
         if (poke && c == 4) begin bus.reg_we = 1'b1; bus.reg_addr = 3'd4; bus.reg_wdata = 32'h0AB; end
         @(negedge clk);
         if (bus.cpu_vram_we) begin
            fwd_seen++;
            fwd_ok = bus.vram_we && bus.vram_addr == 14'h0100 && bus.vram_wdata == 32'hDEAD_BEEF;
         end else if (bus.vram_we) begin
            wa.push_back(bus.vram_addr);
            wd.push_back(bus.vram_wdata);
            wc.push_back(c);
         end
         if (bus.done_pulse) lat = c;
         @(posedge clk);
         #1;
      end
      bus.cpu_vram_we = 1'b0;
      bus.reg_we      = 1'b0;
   endtask

   task automatic test_reset;
      logic [31:0] d;
      rst = 1'b1;
      bus.reg_we = 1'b0; bus.reg_addr = 3'd0; bus.reg_wdata = '0;
      bus.cpu_vram_we = 1'b0; bus.cpu_vram_addr = '0; bus.cpu_vram_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      n_checks++;
      if (bus.busy !== 1'b0 || bus.done_pulse !== 1'b0) begin
         n_fail++; $display("FAIL reset_flags: busy=%b done=%b expected 0 0", bus.busy, bus.done_pulse);
      end
      reg_rd(3'd6, d);
      n_checks++;
      if (d !== 32'd0) begin n_fail++; $display("FAIL reset_status: got %h expected 0", d); end
      reg_rd(3'd4, d);
      n_checks++;
      if (d !== 32'd0) begin n_fail++; $display("FAIL reset_color: got %h expected 0", d); end
      bus.cpu_vram_we = 1'b1; bus.cpu_vram_addr = 14'h1234; bus.cpu_vram_wdata = 32'h55;
      #1;
      n_checks++;
      if (bus.vram_we !== 1'b1 || bus.vram_addr !== 14'h1234 || bus.vram_wdata !== 32'h55) begin
         n_fail++; $display("FAIL reset_passthru: we=%b addr=%h data=%h expected 1 1234 55", bus.vram_we, bus.vram_addr, bus.vram_wdata);
      end
      bus.cpu_vram_we = 1'b0;
      #1;
      n_checks++;
      if (bus.vram_we !== 1'b0) begin n_fail++; $display("FAIL reset_idle_we: got %b expected 0", bus.vram_we); end
   endtask

   task automatic test_basic_fill;
      int exp_a[6] = '{2458, 2459, 2460, 2538, 2539, 2540};
      int lat;
      logic [31:0] d;
      setup_rect(10, 5, 3, 2, 32'hF00);
      start(1'b0);
      capture(50, 0, 1'b0, lat);
      n_checks++;
      if (wa.size() != 6) begin n_fail++; $display("FAIL basic_count: got %0d expected 6", wa.size()); end
      for (int i = 0; i < 6 && i < wa.size(); i++) begin
         n_checks++;
         if (wa[i] !== 14'(exp_a[i]) || wd[i] !== 32'hF00 || wc[i] != i + 2) begin
            n_fail++;
            $display("FAIL basic_write[%0d]: addr=%0d data=%h cycle=%0d expected %0d F00 %0d", i, wa[i], wd[i], wc[i], exp_a[i], i + 2);
         end
      end
      n_checks++;
      if (lat != 8) begin n_fail++; $display("FAIL basic_latency: got %0d expected 8", lat); end
      reg_rd(3'd6, d);
      n_checks++;
      if (d !== 32'h2) begin n_fail++; $display("FAIL basic_status: got %h expected 2", d); end
      reg_wr(3'd6, 32'h2);
      reg_rd(3'd6, d);
      n_checks++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL sticky_clear: got %h expected 0", d); end
   endtask

   task automatic test_page1;
      int exp_a[6] = '{7258, 7259, 7260, 7338, 7339, 7340};
      int lat;
      logic [31:0] d;
      start(1'b1);
      capture(50, 0, 1'b0, lat);
      n_checks++;
      if (wa.size() != 6) begin n_fail++; $display("FAIL page1_count: got %0d expected 6", wa.size()); end
      for (int i = 0; i < 6 && i < wa.size(); i++) begin
         n_checks++;
         if (wa[i] !== 14'(exp_a[i])) begin
            n_fail++; $display("FAIL page1_addr[%0d]: got %0d expected %0d", i, wa[i], exp_a[i]);
         end
      end
      reg_rd(3'd5, d);
      n_checks++;
      if (d !== 32'h2) begin n_fail++; $display("FAIL page1_ctrl_read: got %h expected 2", d); end
   endtask

   task automatic test_full_screen;
      int lat;
      int bad;
      setup_rect(0, 0, 80, 60, 32'h123);
      start(1'b1);
      capture(6000, 0, 1'b0, lat);
      n_checks++;
      if (wa.size() != 4800) begin n_fail++; $display("FAIL full_count: got %0d expected 4800", wa.size()); end
      bad = 0;
      foreach (wa[i]) if (wa[i] !== 14'(6848 + i) || wd[i] !== 32'h123) bad++;
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL full_sequence: %0d wrong writes expected 0", bad); end
      n_checks++;
      if (wa.size() == 0 || wa[$] !== 14'd11647) begin
         n_fail++; $display("FAIL full_last_addr: got %0d expected 11647", (wa.size() == 0) ? -1 : int'(wa[$]));
      end
      n_checks++;
      if (lat != 4802) begin n_fail++; $display("FAIL full_latency: got %0d expected 4802", lat); end
   endtask

   task automatic test_clip;
      int lat;
      setup_rect(78, 59, 5, 4, 32'h0F0);
      start(1'b0);
      capture(50, 0, 1'b0, lat);
      n_checks++;
      if (wa.size() != 2 || wa[0] !== 14'd6846 || wa[1] !== 14'd6847) begin
         n_fail++; $display("FAIL clip_writes: count=%0d first=%0d expected 2 writes 6846 6847", wa.size(), (wa.size() == 0) ? -1 : int'(wa[0]));
      end
      n_checks++;
      if (lat != 4) begin n_fail++; $display("FAIL clip_latency: got %0d expected 4", lat); end
      setup_rect(80, 0, 1, 1, 32'h1);
      start(1'b0);
      capture(20, 0, 1'b0, lat);
      n_checks++;
      if (wa.size() != 0 || lat != 2) begin
         n_fail++; $display("FAIL zero_x: count=%0d latency=%0d expected 0 2", wa.size(), lat);
      end
      setup_rect(0, 60, 4, 4, 32'h1);
      start(1'b0);
      capture(20, 0, 1'b0, lat);
      n_checks++;
      if (wa.size() != 0 || lat != 2) begin
         n_fail++; $display("FAIL zero_y: count=%0d latency=%0d expected 0 2", wa.size(), lat);
      end
   endtask

   task automatic test_cpu_stall;
      int exp_c[3] = '{2, 4, 5};
      int lat;
      setup_rect(0, 0, 3, 1, 32'hABC);
      start(1'b0);
      capture(50, 3, 1'b0, lat);
      n_checks++;
      if (fwd_seen != 1 || !fwd_ok) begin
         n_fail++; $display("FAIL stall_forward: seen=%0d ok=%0d expected 1 1", fwd_seen, fwd_ok);
      end
      n_checks++;
      if (wa.size() != 3) begin n_fail++; $display("FAIL stall_count: got %0d expected 3", wa.size()); end
      for (int i = 0; i < 3 && i < wa.size(); i++) begin
         n_checks++;
         if (wa[i] !== 14'(2048 + i) || wd[i] !== 32'hABC || wc[i] != exp_c[i]) begin
            n_fail++;
            $display("FAIL stall_write[%0d]: addr=%0d data=%h cycle=%0d expected %0d ABC %0d", i, wa[i], wd[i], wc[i], 2048 + i, exp_c[i]);
         end
      end
      n_checks++;
      if (lat != 6) begin n_fail++; $display("FAIL stall_latency: got %0d expected 6", lat); end
   endtask

   task automatic test_busy_writes;
      int exp_a[6] = '{2458, 2459, 2460, 2538, 2539, 2540};
      int lat;
      int restarted;
      logic [31:0] d;
      setup_rect(10, 5, 3, 2, 32'hF00);
      start(1'b0);
      capture(50, 0, 1'b1, lat);
      n_checks++;
      if (wa.size() != 6) begin n_fail++; $display("FAIL busy_count: got %0d expected 6", wa.size()); end
      for (int i = 0; i < 6 && i < wa.size(); i++) begin
         n_checks++;
         if (wa[i] !== 14'(exp_a[i]) || wd[i] !== 32'hF00) begin
            n_fail++; $display("FAIL busy_write[%0d]: addr=%0d data=%h expected %0d F00", i, wa[i], wd[i], exp_a[i]);
         end
      end
      n_checks++;
      if (lat != 8) begin n_fail++; $display("FAIL busy_latency: got %0d expected 8", lat); end
      reg_rd(3'd0, d);
      n_checks++;
      if (d !== 32'd10) begin n_fail++; $display("FAIL busy_x0_kept: got %0d expected 10", d); end
      reg_rd(3'd4, d);
      n_checks++;
      if (d !== 32'hF00) begin n_fail++; $display("FAIL busy_color_kept: got %h expected F00", d); end
      restarted = 0;
      repeat (5) begin
         @(negedge clk);
         if (bus.busy !== 1'b0) restarted++;
      end
      n_checks++;
      if (restarted != 0) begin n_fail++; $display("FAIL busy_no_restart: busy cycles=%0d expected 0", restarted); end
   endtask

   task automatic test_reset_mid;
      int lat;
      int bad;
      logic [31:0] d;
      setup_rect(0, 0, 80, 60, 32'h777);
      start(1'b0);
      capture(10, 0, 1'b0, lat);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      n_checks++;
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
      reg_rd(3'd6, d);
      n_checks++;
      if (d !== 32'd0) begin n_fail++; $display("FAIL midrst_status: got %h expected 0", d); end
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         bus.cpu_vram_we   = i[0];
         bus.cpu_vram_addr = 14'(i + 32);
         @(negedge clk);
         if (bus.done_pulse !== 1'b0 || bus.vram_we !== i[0] ||
             (i[0] && bus.vram_addr !== 14'(i + 32))) bad++;
      end
      bus.cpu_vram_we = 1'b0;
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL midrst_passthru: bad cycles=%0d expected 0", bad); end
   endtask

   initial begin
      test_reset();
      test_basic_fill();
      test_page1();
      test_full_screen();
      test_clip();
      test_cpu_stall();
      test_busy_writes();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/vram_rect_fill.md
Name: vram_rect_fill

Overview:
- Memory-mapped rectangle-fill engine that writes the VRAM feeding the VGA scan-out stage, through that RAM's write port (port A).
- Scan-out reads 80x60 tiles (8x8 pixels each); each tile is a 32-bit word holding 12-bit RGB in bits [11:0].
- Tile (x,y) on page 0 lives at word address 2048 + y*80 + x; on page 1 at 6848 + y*80 + x.
- Software programs a rectangle, colour and page, then kicks the engine. The engine streams one tile write per cycle. CPU stores to VRAM are merged onto the same port with priority.

Parameters:
- COLS, 80, tiles per row
- ROWS, 60, tile rows
- PAGE0_BASE, 2048, word address of tile (0,0) on page 0
- PAGE1_BASE, 6848, word address of tile (0,0) on page 1

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- reg_we  in  1  register write strobe
- reg_addr  in  3  register select
- reg_wdata  in  32  register write data
- reg_rdata  out  32  combinational read of the selected register
- cpu_vram_we  in  1  CPU store to VRAM
- cpu_vram_addr  in  14  CPU store address
- cpu_vram_wdata  in  32  CPU store data
- vram_we  out  1  VRAM port A write enable
- vram_addr  out  14  VRAM port A address
- vram_wdata  out  32  VRAM port A data
- busy  out  1  engine active (state != IDLE)
- done_pulse  out  1  one-cycle completion strobe

Behaviour:
- Reset: rst, synchronous, active-high; clock clk. All registers, counters and sticky bits go to 0, FSM to IDLE. busy=0, done_pulse=0. vram_* simply pass the CPU inputs.
- Register map:
  - 0 X0[6:0]
  - 1 Y0[5:0]
  - 2 W[6:0]
  - 3 H[5:0]
  - 4 COLOR[31:0]
  - 5 CTRL: bit0 start (self-clearing, reads 0), bit1 page
  - 6 STATUS, read-only: bit0 busy, bit1 done_sticky
  - 7 reads 0
  - Unused bits read 0.
- While busy, writes to regs 0-5 are ignored, including start.
- Writing reg 6 with bit1=1 clears done_sticky.
- FSM IDLE -> SETUP -> RUN -> DONE -> IDLE.
- IDLE: a reg write of CTRL with bit0=1 at edge N moves to SETUP (busy=1 from N+1). The same write latches the page bit.
- SETUP, one cycle: clipping and row base.
  - w_eff = (X0>=COLS) ? 0 : min(W, COLS-X0)
  - h_eff = (Y0>=ROWS) ? 0 : min(H, ROWS-Y0)
  - row_addr = base(page) + Y0*80, computed as (Y0<<6)+(Y0<<4), 14-bit.
  - If w_eff==0 or h_eff==0, go to DONE with no writes. Otherwise go to RUN with col=0, row=0.
- RUN:
  - Each cycle with cpu_vram_we=0 issues vram_we=1, vram_addr=row_addr+X0+col, vram_wdata=COLOR.
  - col increments; at col==w_eff-1 it wraps to 0, row increments, and row_addr += 80.
  - After the write with row==h_eff-1 and col==w_eff-1, go to DONE.
  - A cycle with cpu_vram_we=1 forwards the CPU store unchanged and the engine holds all counters (stall). There is no lost or duplicated tile.
- DONE, one cycle: done_pulse=1, done_sticky<=1, then IDLE (busy=0 the following cycle).
- Write count: exactly w_eff*h_eff engine writes. Fill-only latency = 2 + w_eff*h_eff + stall cycles from start edge to done_pulse.
- Mux outside RUN: vram_we/addr/wdata = cpu_vram_* (combinational).
- Address width: the maximum address is 6848+4799 = 11647, which fits in 14 bits with no wrap.
- Reset mid-operation: the FSM returns to IDLE the next edge and the remaining writes are abandoned. done_sticky is cleared and no done_pulse is issued.
- COLOR and page are latched at start in working registers. Later CPU register writes (ignored anyway) cannot alter an in-flight fill.

Test Plan:
- X0=10, Y0=5, W=3, H=2, COLOR=0xF00, page0, start -> writes 2458, 2459, 2460, 2538, 2539, 2540 with data 0xF00 on consecutive cycles. done_pulse 8 cycles after the start edge. STATUS reads 0x2.
- Same rectangle on page1 -> addresses 7258, 7259, 7260, 7338, 7339, 7340. Full screen (0,0,80,60) page1 -> 4800 writes, last address 11647.
- Clipping: X0=78, W=5, Y0=59, H=4 -> 2 writes (addresses 2048+4720+78=6846, 6847). X0=80, W=1 -> no writes, done_pulse at 2 cycles.
- CPU store at 0x0100 asserted in RUN cycle 2 of a 3x1 fill -> that cycle forwards addr 0x0100 unchanged. Engine completes 3 writes with no gaps or duplicates; done_pulse is delayed by 1.
- start written while busy, and X0 rewritten while busy -> no restart, address pattern unchanged. rst asserted mid-fill -> next cycle busy=0, vram_we follows cpu_vram_we only, STATUS=0.
